score_ctrl: RTL and testbench
=============================

# score_ctrl

Score-keeping and display sequencer for the pong playfield. Counts points for both players in BCD, runs the post-point flash/freeze sequence and game-over detection, and drives the four active-low 7-segment codes consumed by the on-screen digit renderers (two per player). It sits between the ball/collision logic, which supplies point pulses, and the VGA overlay.

## Interface
- WIN_SCORE, 11: score that ends the game; legal range 1..99.
- FLASH_FRAMES, 90: length of the post-point flash, in frame ticks.
- BLINK_FRAMES, 15: half-period of the blink during flash, in frame ticks; must be ≥1.
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle pulse per video frame.
- p1_point  in  1  one-cycle pulse: player 1 scored.
- p2_point  in  1  one-cycle pulse: player 2 scored.
- new_game  in  1  level/pulse; restarts from GAME_OVER only.
- seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones  out  7 each  active-low segment codes; bit0=a(top), 1=b(upper right), 2=c(lower right), 3=d(bottom), 4=e(lower left), 5=f(upper left), 6=g(middle).
- freeze  out  1  high while the ball must be held (FLASH, GAME_OVER).
- game_over  out  1  high in GAME_OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2; valid while game_over.

## Operation
- Scores: two BCD digits per player (tens, ones). Increment: ones 9→0 with tens+1. Scores never exceed WIN_SCORE.
- States: PLAY, FLASH, GAME_OVER.
- PLAY: a point pulse increments that player's score, records the scorer(s) in a 2-bit flash mask, clears the flash and blink counters, and moves to FLASH.
- FLASH: freeze=1. flash_cnt counts tick pulses. blink_cnt counts ticks to BLINK_FRAMES-1, then wraps and toggles blink_phase (starts 0 = visible). While blink_phase=1, both digits of every masked player output 7'h7F. When flash_cnt reaches FLASH_FRAMES-1 on a tick: go to GAME_OVER if either score equals WIN_SCORE, else PLAY.
- A point during FLASH is counted. It ORs into the mask, and both counters and blink_phase restart.
- GAME_OVER: freeze=1, game_over=1, and winner holds the player(s) at WIN_SCORE. Point pulses are ignored. new_game clears both scores, mask and winner, then returns to PLAY.
- Simultaneous p1_point and p2_point: both increment, the mask is 11, and winner can be 11 if both reach WIN_SCORE.
- Decode: BCD 0–9 maps to standard active-low patterns, e.g. 0=7'b1000000, 1=7'b1111001, 2=7'b0100100. A tens digit of 0 is blanked (7'h7F). Ones is always shown unless blinked.

## Timing
- The score registers update on the edge that samples the point pulse (cycle N). The state changes on the same edge.
- seg_* outputs are registered from the scores and blink_phase, so they reflect the new value at N+1.
- freeze and game_over are registered from state and are valid in the cycle after the state edge.
- A tick coincident with entry to FLASH is not counted. A tick coincident with a point in FLASH is absorbed by the restart.
- Reset has priority over all inputs, on any cycle and in any state. Reset values: state PLAY, scores 0, counters 0, mask 0, blink_phase 0, seg_*_ones=7'b1000000, seg_*_tens=7'h7F, freeze=0, game_over=0, winner=00.
- new_game has no effect outside GAME_OVER.

## Structure
- The shared package holds:
  - the state encoding (PLAY, FLASH, GAME_OVER);
  - the BCD-to-segment constants;
  - the blank code 7'h7F;
  - the segment bit-index constants shared with the digit renderer.
- One sub-module, bcd_to_seg: a combinational 4-bit BCD to active-low 7-bit decoder. It is instantiated four times. Out-of-range inputs produce 7'h7F.

## Test plan
- Reset, then idle for 10 ticks: ones digits 7'b1000000, tens digits 7'h7F, freeze=0, state PLAY.
- One p1_point: seg_p1_ones=7'b1111001 one cycle later; freeze=1. After BLINK_FRAMES ticks the p1 digits read 7'h7F while the p2 digits are unchanged. After FLASH_FRAMES ticks, freeze=0.
- Ten p1_points, each letting the flash expire: p1 tens=7'b1111001 and p1 ones=7'b1000000 (score 10).
- With WIN_SCORE=3, three p2_points: after the final flash game_over=1, winner=10, and further points do not change the digits. new_game returns everything to the reset digit values with freeze=0.
- p1_point and p2_point in the same cycle: both ones digits read 1 and both players blink. A second p1_point mid-flash restarts the flash, so freeze stays high for a full FLASH_FRAMES from the second point.
- Assert reset mid-FLASH while blink_phase=1: the next cycle shows the reset values, and freeze=0.

Source files
------------

// File: rtl/score_ctrl_pkg.sv
// Shared definitions for the pong score/display sequencer and its digit renderers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, active-low 7-segment patterns for BCD 0-9,
// the blank code, segment bit indices (bit0=a ... bit6=g) and BCD helpers.
package score_ctrl_pkg;

  // Sequencer states
  localparam logic [1:0] ST_PLAY      = 2'd0;
  localparam logic [1:0] ST_FLASH     = 2'd1;
  localparam logic [1:0] ST_GAME_OVER = 2'd2;

  // Segment bit positions inside a 7-bit code (shared with the digit renderer)
  localparam int SEG_A = 0;  // top
  localparam int SEG_B = 1;  // upper right
  localparam int SEG_C = 2;  // lower right
  localparam int SEG_D = 3;  // bottom
  localparam int SEG_E = 4;  // lower left
  localparam int SEG_F = 5;  // upper left
  localparam int SEG_G = 6;  // middle

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low digit patterns; a 0 bit lights the segment
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Binary value of a two-digit BCD score (max 99, fits in 7 bits)
  function automatic logic [6:0] bcd_value(input logic [3:0] tens,
                                           input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  // Two-digit BCD increment, returned as {tens, ones}.
  // Callers saturate at the win score (<= 99), so tens never passes 9.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] ones);
    logic [7:0] r;
    if (ones == 4'd9) begin
      r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/score_ctrl_bcd_to_seg.sv
// BCD digit to active-low 7-segment decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   bcd  in  4  BCD digit; 10..15 are treated as invalid
//   seg  out 7  active-low segment code (bit0=a ... bit6=g); invalid -> blank
module bcd_to_seg
  import score_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_ctrl.sv
// Pong score keeper and post-point flash / game-over sequencer driving four 7-seg codes.
// Latency: scores and state update on the point edge; seg/freeze/game_over/winner one cycle later.
// Backpressure: none; point, tick and new_game pulses are consumed on the cycle they appear.
//
// Ports:
//   clk        in   system/pixel clock
//   reset      in   synchronous active-high reset, highest priority
//   tick       in   one-cycle pulse per video frame
//   p1_point   in   one-cycle pulse: player 1 scored
//   p2_point   in   one-cycle pulse: player 2 scored
//   new_game   in   restarts play, honoured only in GAME_OVER
//   seg_p*_*   out  active-low 7-segment codes, tens blanked when zero
//   freeze     out  hold the ball (FLASH or GAME_OVER)
//   game_over  out  high in GAME_OVER
//   winner     out  {p2, p1} at the win score, valid while game_over
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int FLASH_FRAMES = 90,
  parameter int BLINK_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_game,
  output logic [6:0] seg_p1_tens,
  output logic [6:0] seg_p1_ones,
  output logic [6:0] seg_p2_tens,
  output logic [6:0] seg_p2_ones,
  output logic       freeze,
  output logic       game_over,
  output logic [1:0] winner
);

  // Counter widths sized so the terminal value always fits (also for a value of 1)
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [6:0]    WIN_VAL    = 7'(WIN_SCORE);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [1:0]    state;
  logic [3:0]    p1_tens, p1_ones;
  logic [3:0]    p2_tens, p2_ones;
  logic [FW-1:0] flash_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;   // 0 = digits visible, 1 = masked digits blanked
  logic [1:0]    flash_mask;    // {p2, p1}: players whose digits blink

  logic       any_point;
  logic       score_en;
  logic       p1_at_win, p2_at_win;
  logic [7:0] p1_inc, p2_inc;

  assign any_point = p1_point | p2_point;
  assign score_en  = any_point && ((state == ST_PLAY) || (state == ST_FLASH));
  assign p1_at_win = (bcd_value(p1_tens, p1_ones) == WIN_VAL);
  assign p2_at_win = (bcd_value(p2_tens, p2_ones) == WIN_VAL);
  assign p1_inc    = bcd_inc(p1_tens, p1_ones);
  assign p2_inc    = bcd_inc(p2_tens, p2_ones);

  // ---------------------------------------------------------------------------
  // Score registers. A score already at WIN_SCORE saturates; a further point
  // during FLASH still restarts the flash (handled in the sequencer below).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_tens <= 4'd0;
      p1_ones <= 4'd0;
      p2_tens <= 4'd0;
      p2_ones <= 4'd0;
    end else if ((state == ST_GAME_OVER) && new_game) begin
      p1_tens <= 4'd0;
      p1_ones <= 4'd0;
      p2_tens <= 4'd0;
      p2_ones <= 4'd0;
    end else if (score_en) begin
      if (p1_point && !p1_at_win) begin
        {p1_tens, p1_ones} <= p1_inc;
      end
      if (p2_point && !p2_at_win) begin
        {p2_tens, p2_ones} <= p2_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: PLAY -> FLASH on a point, FLASH -> PLAY/GAME_OVER when the
  // flash expires, GAME_OVER -> PLAY on new_game.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PLAY;
      flash_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      flash_mask  <= 2'b00;
    end else begin
      case (state)
        ST_PLAY: begin
          // A tick on the entry cycle is deliberately not counted
          if (any_point) begin
            state       <= ST_FLASH;
            flash_mask  <= {p2_point, p1_point};
            flash_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
          end
        end

        ST_FLASH: begin
          if (any_point) begin
            // New point restarts the whole flash; a coincident tick is absorbed
            flash_mask  <= flash_mask | {p2_point, p1_point};
            flash_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
          end else if (tick) begin
            if (flash_cnt == FLASH_LAST) begin
              flash_cnt   <= '0;
              blink_cnt   <= '0;
              blink_phase <= 1'b0;
              if (p1_at_win || p2_at_win) begin
                // Mask is kept until new_game; blanking is gated by FLASH anyway
                state <= ST_GAME_OVER;
              end else begin
                state      <= ST_PLAY;
                flash_mask <= 2'b00;
              end
            end else begin
              flash_cnt <= flash_cnt + 1'b1;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
        end

        ST_GAME_OVER: begin
          if (new_game) begin
            state      <= ST_PLAY;
            flash_mask <= 2'b00;
          end
        end

        default: begin
          state       <= ST_PLAY;
          flash_cnt   <= '0;
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
          flash_mask  <= 2'b00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display path: decode each digit, then register with blanking applied.
  // ---------------------------------------------------------------------------
  logic [6:0] p1_tens_seg, p1_ones_seg;
  logic [6:0] p2_tens_seg, p2_ones_seg;

  bcd_to_seg u_p1_tens (.bcd(p1_tens), .seg(p1_tens_seg));
  bcd_to_seg u_p1_ones (.bcd(p1_ones), .seg(p1_ones_seg));
  bcd_to_seg u_p2_tens (.bcd(p2_tens), .seg(p2_tens_seg));
  bcd_to_seg u_p2_ones (.bcd(p2_ones), .seg(p2_ones_seg));

  logic blink_p1, blink_p2;

  assign blink_p1 = (state == ST_FLASH) && blink_phase && flash_mask[0];
  assign blink_p2 = (state == ST_FLASH) && blink_phase && flash_mask[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p1_tens <= SEG_BLANK;
      seg_p1_ones <= SEG_0;
      seg_p2_tens <= SEG_BLANK;
      seg_p2_ones <= SEG_0;
      freeze      <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      // Leading zero in the tens place is never shown
      seg_p1_tens <= (blink_p1 || (p1_tens == 4'd0)) ? SEG_BLANK : p1_tens_seg;
      seg_p1_ones <= blink_p1 ? SEG_BLANK : p1_ones_seg;
      seg_p2_tens <= (blink_p2 || (p2_tens == 4'd0)) ? SEG_BLANK : p2_tens_seg;
      seg_p2_ones <= blink_p2 ? SEG_BLANK : p2_ones_seg;
      freeze      <= (state != ST_PLAY);
      game_over   <= (state == ST_GAME_OVER);
      winner      <= (state == ST_GAME_OVER) ? {p2_at_win, p1_at_win} : 2'b00;
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl: two instances (default and short-game parameters)
// share one stimulus stream and are compared every cycle against a score/tick-count model.
// Directed scenarios walk the main sequences; a random phase follows.
module tb_score_ctrl;

  localparam int M_PLAY  = 0;
  localparam int M_FLASH = 1;
  localparam int M_OVER  = 2;
  localparam logic [6:0] BLANK = 7'h7F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic p1_point = 1'b0;
  logic p2_point = 1'b0;
  logic new_game = 1'b0;

  logic [6:0] d0_p1t, d0_p1o, d0_p2t, d0_p2o;
  logic       d0_frz, d0_go;
  logic [1:0] d0_win;
  logic [6:0] d1_p1t, d1_p1o, d1_p2t, d1_p2o;
  logic       d1_frz, d1_go;
  logic [1:0] d1_win;

  always #5 clk = ~clk;

  score_ctrl #(.WIN_SCORE(11), .FLASH_FRAMES(90), .BLINK_FRAMES(15)) u_dut0 (
    .clk(clk), .reset(reset), .tick(tick), .p1_point(p1_point), .p2_point(p2_point),
    .new_game(new_game), .seg_p1_tens(d0_p1t), .seg_p1_ones(d0_p1o),
    .seg_p2_tens(d0_p2t), .seg_p2_ones(d0_p2o), .freeze(d0_frz),
    .game_over(d0_go), .winner(d0_win));

  score_ctrl #(.WIN_SCORE(3), .FLASH_FRAMES(8), .BLINK_FRAMES(3)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick), .p1_point(p1_point), .p2_point(p2_point),
    .new_game(new_game), .seg_p1_tens(d1_p1t), .seg_p1_ones(d1_p1o),
    .seg_p2_tens(d1_p2t), .seg_p2_ones(d1_p2o), .freeze(d1_frz),
    .game_over(d1_go), .winner(d1_win));

  // Standard active-low digit shapes, bit0=a .. bit6=g
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int cfg_win   [2] = '{11, 3};
  int cfg_flash [2] = '{90, 8};
  int cfg_blink [2] = '{15, 3};

  // Model state: mode, integer scores, ticks counted since the flash (re)started
  int         m_mode [2];
  int         m_s1 [2];
  int         m_s2 [2];
  int         m_ticks [2];
  logic [1:0] m_mask [2];

  logic [6:0] e_p1t [2];
  logic [6:0] e_p1o [2];
  logic [6:0] e_p2t [2];
  logic [6:0] e_p2o [2];
  logic       e_frz [2];
  logic       e_go [2];
  logic [1:0] e_win [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Displayed values follow from the model state one edge earlier
  task automatic expose(input int i);
    bit blink, b1, b2;
    blink = (m_mode[i] == M_FLASH) && (((m_ticks[i] / cfg_blink[i]) % 2) == 1);
    b1 = blink && m_mask[i][0];
    b2 = blink && m_mask[i][1];
    e_p1t[i] = (b1 || (m_s1[i] / 10 == 0)) ? BLANK : seg_tab[m_s1[i] / 10];
    e_p1o[i] = b1 ? BLANK : seg_tab[m_s1[i] % 10];
    e_p2t[i] = (b2 || (m_s2[i] / 10 == 0)) ? BLANK : seg_tab[m_s2[i] / 10];
    e_p2o[i] = b2 ? BLANK : seg_tab[m_s2[i] % 10];
    e_frz[i] = (m_mode[i] != M_PLAY);
    e_go[i]  = (m_mode[i] == M_OVER);
    e_win[i] = (m_mode[i] == M_OVER) ? {m_s2[i] == cfg_win[i], m_s1[i] == cfg_win[i]} : 2'b00;
  endtask

  task automatic score(input int i, input bit p1, input bit p2);
    if (p1 && m_s1[i] < cfg_win[i]) m_s1[i]++;
    if (p2 && m_s2[i] < cfg_win[i]) m_s2[i]++;
  endtask

  task automatic model_step(input int i, input bit rst, input bit p1, input bit p2,
                            input bit tk, input bit ng);
    if (!rst) expose(i);
    if (rst) begin
      m_mode[i] = M_PLAY; m_s1[i] = 0; m_s2[i] = 0; m_ticks[i] = 0; m_mask[i] = 2'b00;
      expose(i);
    end else if (m_mode[i] == M_PLAY) begin
      if (p1 || p2) begin
        score(i, p1, p2);
        m_mask[i] = {p2, p1};
        m_ticks[i] = 0;
        m_mode[i] = M_FLASH;
      end
    end else if (m_mode[i] == M_FLASH) begin
      if (p1 || p2) begin
        score(i, p1, p2);
        m_mask[i] = m_mask[i] | {p2, p1};
        m_ticks[i] = 0;
      end else if (tk) begin
        m_ticks[i]++;
        if (m_ticks[i] == cfg_flash[i]) begin
          m_ticks[i] = 0;
          if (m_s1[i] == cfg_win[i] || m_s2[i] == cfg_win[i]) begin
            m_mode[i] = M_OVER;
          end else begin
            m_mode[i] = M_PLAY;
            m_mask[i] = 2'b00;
          end
        end
      end
    end else begin
      if (ng) begin
        m_mode[i] = M_PLAY; m_s1[i] = 0; m_s2[i] = 0; m_ticks[i] = 0; m_mask[i] = 2'b00;
      end
    end
  endtask

  task automatic compare_all();
    chk("d0.seg_p1_tens", d0_p1t, e_p1t[0]);
    chk("d0.seg_p1_ones", d0_p1o, e_p1o[0]);
    chk("d0.seg_p2_tens", d0_p2t, e_p2t[0]);
    chk("d0.seg_p2_ones", d0_p2o, e_p2o[0]);
    chk("d0.freeze", d0_frz, e_frz[0]);
    chk("d0.game_over", d0_go, e_go[0]);
    chk("d0.winner", d0_win, e_win[0]);
    chk("d1.seg_p1_tens", d1_p1t, e_p1t[1]);
    chk("d1.seg_p1_ones", d1_p1o, e_p1o[1]);
    chk("d1.seg_p2_tens", d1_p2t, e_p2t[1]);
    chk("d1.seg_p2_ones", d1_p2o, e_p2o[1]);
    chk("d1.freeze", d1_frz, e_frz[1]);
    chk("d1.game_over", d1_go, e_go[1]);
    chk("d1.winner", d1_win, e_win[1]);
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample #1 later
  task automatic cyc(input bit rst, input bit p1, input bit p2, input bit tk, input bit ng);
    reset = rst; p1_point = p1; p2_point = p2; tick = tk; new_game = ng;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, rst, p1, p2, tk, ng);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset, then idle frames
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 1, 0);
    chk("idle_p1_ones", d0_p1o, 7'b1000000);
    chk("idle_p1_tens", d0_p1t, 7'h7F);
    chk("idle_p2_ones", d0_p2o, 7'b1000000);
    chk("idle_freeze", d0_frz, 1'b0);

    // Single p1 point: digit, freeze, blink, flash expiry
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pt_p1_ones", d0_p1o, 7'b1111001);
    chk("pt_freeze", d0_frz, 1'b1);
    repeat (15) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("blink_p1_ones", d0_p1o, 7'h7F);
    chk("blink_p1_tens", d0_p1t, 7'h7F);
    chk("blink_p2_ones", d0_p2o, 7'b1000000);
    repeat (74) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("flash_89_freeze", d0_frz, 1'b1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("flash_end_freeze", d0_frz, 1'b0);

    // Nine more points reach 10
    repeat (9) begin
      cyc(0, 1, 0, 0, 0);
      repeat (95) cyc(0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("ten_p1_tens", d0_p1t, 7'b1111001);
    chk("ten_p1_ones", d0_p1o, 7'b1000000);

    // Short game on the second instance: p2 reaches 3
    cyc(1, 0, 0, 0, 0);
    repeat (3) begin
      cyc(0, 0, 1, 0, 0);
      repeat (12) cyc(0, 0, 0, 1, 0);
    end
    chk("go_game_over", d1_go, 1'b1);
    chk("go_winner", d1_win, 2'b10);
    chk("go_freeze", d1_frz, 1'b1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("go_hold_p2_ones", d1_p2o, 7'b0110000);
    chk("go_hold_p1_ones", d1_p1o, 7'b1000000);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("ng_freeze", d1_frz, 1'b0);
    chk("ng_game_over", d1_go, 1'b0);
    chk("ng_p2_ones", d1_p2o, 7'b1000000);
    chk("ng_p2_tens", d1_p2t, 7'h7F);
    chk("ng_winner", d1_win, 2'b00);

    // Simultaneous points, then a restarting point mid-flash
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("both_p1_ones", d0_p1o, 7'b1111001);
    chk("both_p2_ones", d0_p2o, 7'b1111001);
    repeat (15) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("both_blink_p1", d0_p1o, 7'h7F);
    chk("both_blink_p2", d0_p2o, 7'h7F);
    repeat (20) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (89) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("restart_freeze_held", d0_frz, 1'b1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("restart_freeze_drop", d0_frz, 1'b0);
    chk("restart_p1_ones", d0_p1o, 7'b0100100);

    // Reset while the blink is in its blanked half
    cyc(0, 0, 1, 0, 0);
    repeat (15) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_blank", d0_p2o, 7'h7F);
    cyc(1, 0, 0, 0, 0);
    chk("rst_p2_ones", d0_p2o, 7'b1000000);
    chk("rst_p2_tens", d0_p2t, 7'h7F);
    chk("rst_freeze", d0_frz, 1'b0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(499) == 0, $urandom_range(39) == 0, $urandom_range(39) == 0,
          $urandom_range(1) == 0, $urandom_range(19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
